// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = WORD_BYTES * 8;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    // Host / environment side
    modport master (
        output in_valid, in_data, reload,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );

    // Loader side
    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );

endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: bytes enter at the top of the shift
// register so the first byte of a word ends up in bits [7:0].
module byte_to_word
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Next-state of counter and shift register; word_o already includes the byte accepted this cycle
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (shift_i) begin
            cnt_d  = cnt_q + CNT_W'(1);
            word_d = {byte_i, word_q[WORD_W-1:8]};
        end
        word_o       = word_d;
        word_ready_o = shift_i && !clr_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
    end

    // Counter and assembly register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes little-endian words
// to instruction memory from address 0 and keeps the CPU in reset until done.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              in_ready_q, mem_we_q, cpu_rst_q, done_q, err_q;

    logic              xfer;
    logic              b2w_clr, b2w_shift, word_ready;
    logic [WORD_W-1:0] word;

    assign xfer = bus.in_valid && in_ready_q;

    byte_to_word u_b2w (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (b2w_clr),
        .shift_i      (b2w_shift),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // Next-state logic for the load sequence
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        b2w_clr   = 1'b0;
        b2w_shift = 1'b0;
        unique case (state_q)
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.in_data;
                    if ({bus.in_data, len_q[7:0]} == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, bus.in_data, len_q[7:0]} > DEPTH_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                b2w_shift = xfer;
                // Address and data are captured here so they hold steady after the write
                if (word_ready) begin
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d = idx_q + 1'b1;
                if (17'(idx_q) + 17'd1 == {1'b0, len_q}) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            DONE: begin
                if (bus.reload) begin
                    idx_d   = '0;
                    b2w_clr = 1'b1;
                    state_d = LEN_LO;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = LEN_LO;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state
    // so they line up with state_q without any path from in_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LEN_LO;
            len_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
            mem_we_q   <= (state_d == WRITE);
            cpu_rst_q  <= (state_d != DONE);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
